// File: rtl/vga_pixel_if.sv
// Pixel-write interface between the game datapath / fly animations and the VGA pixel sink.
// The master drives writes and clear requests; the slave reports clear-engine status and rejects.
interface vga_pixel_if #(
    parameter int unsigned COLOUR_W = 3
);
    logic [8:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                clear;
    logic [COLOUR_W-1:0] bg_colour;
    logic                busy;
    logic [7:0]          drop_count;

    modport master (
        output x, y, colour, plot, clear, bg_colour,
        input  busy, drop_count
    );

    modport slave (
        input  x, y, colour, plot, clear, bg_colour,
        output busy, drop_count
    );
endinterface

// File: rtl/vga_pixel_sink.sv
// Frame-buffer sink for x/y/colour/plot writes, scanned out as 640x480 VGA with 2x2 pixel doubling.
// Includes a background-clear engine and a saturating count of rejected writes.
module vga_pixel_sink #(
    parameter int unsigned H_RES    = 320,
    parameter int unsigned V_RES    = 240,
    parameter int unsigned COLOUR_W = 3,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic                clock,
    input  logic                reset,
    vga_pixel_if.slave          pix,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic                vga_pix_en,
    output logic                frame_start
);

    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned N_PIX    = H_RES * V_RES;
    localparam int unsigned ADDR_W   = $clog2(N_PIX);
    localparam int unsigned HC_W     = $clog2(H_TOTAL);
    localparam int unsigned VC_W     = $clog2(V_TOTAL);
    localparam int unsigned HS_FIRST = H_VIS + H_FP;
    localparam int unsigned HS_LAST  = H_VIS + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_VIS + V_FP;
    localparam int unsigned VS_LAST  = V_VIS + V_FP + V_SYNC - 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    logic                pix_en;
    logic [HC_W-1:0]     h_cnt;
    logic [VC_W-1:0]     v_cnt;
    logic                h_last_c;
    logic                v_last_c;
    logic                vis_c;
    logic                hs_c;
    logic                vs_c;
    logic [ADDR_W-1:0]   rd_addr_c;

    logic [COLOUR_W-1:0] mem [N_PIX];
    logic [COLOUR_W-1:0] ram_q;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic [ADDR_W-1:0]   clr_addr_d;
    logic                in_range_c;
    logic [ADDR_W-1:0]   plot_addr_c;
    logic                we_c;
    logic [ADDR_W-1:0]   wr_addr_c;
    logic [COLOUR_W-1:0] wr_data_c;
    logic                drop_c;

    // Scan position decode from the live counters.
    always_comb begin
        h_last_c  = (h_cnt == HC_W'(H_TOTAL - 1));
        v_last_c  = (v_cnt == VC_W'(V_TOTAL - 1));
        vis_c     = (32'(h_cnt) < H_VIS) && (32'(v_cnt) < V_VIS);
        hs_c      = !((32'(h_cnt) >= HS_FIRST) && (32'(h_cnt) <= HS_LAST));
        vs_c      = !((32'(v_cnt) >= VS_FIRST) && (32'(v_cnt) <= VS_LAST));
        rd_addr_c = '0;
        if (vis_c) begin
            rd_addr_c = ADDR_W'(ADDR_W'(v_cnt >> 1) * ADDR_W'(H_RES) + ADDR_W'(h_cnt >> 1));
        end
    end

    // Pixel-clock enable and raster counters; counters move on every other clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_en <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (h_last_c) begin
                    h_cnt <= '0;
                    v_cnt <= v_last_c ? '0 : v_cnt + VC_W'(1);
                end else begin
                    h_cnt <= h_cnt + HC_W'(1);
                end
            end
        end
    end

    assign vga_pix_en = pix_en;

    // Frame buffer: one write port, registered read; a same-edge collision reads old data.
    always_ff @(posedge clock) begin
        if (we_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
        ram_q <= mem[rd_addr_c];
    end

    // Output stage loads once per pixel period, one period behind the counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_colour  <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_last_c && v_last_c;
            if (pix_en) begin
                vga_blank_n <= vis_c;
                vga_hs      <= hs_c;
                vga_vs      <= vs_c;
                vga_colour  <= vis_c ? ram_q : '0;
            end
        end
    end

    always_comb begin
        in_range_c  = (32'(pix.x) < H_RES) && (32'(pix.y) < V_RES);
        plot_addr_c = ADDR_W'(ADDR_W'(pix.y) * ADDR_W'(H_RES) + ADDR_W'(pix.x));
    end

    // Write arbitration between the plot port and the clear engine.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        we_c       = 1'b0;
        wr_addr_c  = clr_addr_q;
        wr_data_c  = pix.bg_colour;
        drop_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix.plot) begin
                    if (in_range_c) begin
                        we_c      = 1'b1;
                        wr_addr_c = plot_addr_c;
                        wr_data_c = pix.colour;
                    end else begin
                        drop_c = 1'b1;
                    end
                end
                if (pix.clear) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                we_c   = 1'b1;
                drop_c = pix.plot;
                if (clr_addr_q == ADDR_W'(N_PIX - 1)) begin
                    state_d = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            clr_addr_q     <= '0;
            pix.busy       <= 1'b0;
            pix.drop_count <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            pix.busy   <= (state_d == CLEAR);
            if (drop_c && (pix.drop_count != 8'hFF)) begin
                pix.drop_count <= pix.drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Randomised bench for vga_pixel_sink against a position/time reference model of the raster.
// Runs a reduced raster geometry so full frames fit in a short simulation.
module tb_vga_pixel_sink;

    localparam int unsigned H_RES     = 8;
    localparam int unsigned V_RES     = 6;
    localparam int unsigned COLOUR_W  = 3;
    localparam int unsigned H_VIS     = 16;
    localparam int unsigned H_FP      = 2;
    localparam int unsigned H_SYNC    = 4;
    localparam int unsigned H_BP      = 2;
    localparam int unsigned V_VIS     = 12;
    localparam int unsigned V_FP      = 2;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 2;
    localparam int unsigned HT        = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT        = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned NPIX      = H_RES * V_RES;
    localparam int unsigned FRAME_Q   = HT * VT;
    localparam int unsigned FRAME_CLK = 2 * FRAME_Q;
    localparam int unsigned PART_WR   = 19;

    logic                clock;
    logic                reset;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_hs;
    logic                vga_vs;
    logic                vga_blank_n;
    logic                vga_pix_en;
    logic                frame_start;

    vga_pixel_if #(.COLOUR_W(COLOUR_W)) pix ();

    vga_pixel_sink #(
        .H_RES(H_RES), .V_RES(V_RES), .COLOUR_W(COLOUR_W),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pix         (pix),
        .vga_colour  (vga_colour),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_pix_en  (vga_pix_en),
        .frame_start (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned tests_run;
    int unsigned tests_failed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: buffer contents, clear engine, drop counter, expected scan outputs.
    logic [COLOUR_W-1:0] m_mem [NPIX];
    bit                  m_known [NPIX];
    bit                  m_busy;
    int unsigned         m_addr;
    int unsigned         m_drop;
    logic [COLOUR_W-1:0] m_rd;
    bit                  m_rd_known;
    int unsigned         edge_n;
    int unsigned         cyc;
    bit                  e_hs, e_vs, e_blank, e_fs, e_ck;
    logic [COLOUR_W-1:0] e_colour;

    int unsigned hs_low, vs_low, fs_cnt, fs_first, fs_last, fs_gap, busy_cnt;
    int unsigned cnt_a, cnt_b, bad_blank, plots_in_clear;
    logic [COLOUR_W-1:0] col_a, col_b;
    bit found;

    function automatic bit pos_vis(input int unsigned q);
        return ((q % HT) < H_VIS) && (((q / HT) % VT) < V_VIS);
    endfunction

    function automatic int unsigned pos_addr(input int unsigned q);
        return (((q / HT) % VT) / 2) * H_RES + (q % HT) / 2;
    endfunction

    task automatic model_reset();
        edge_n   = 0;
        cyc      = 0;
        m_busy   = 1'b0;
        m_addr   = 0;
        m_drop   = 0;
        e_hs     = 1'b1;
        e_vs     = 1'b1;
        e_blank  = 1'b0;
        e_colour = '0;
        e_ck     = 1'b1;
        e_fs     = 1'b0;
    endtask

    // Effect of the coming clock edge, using the inputs currently driven.
    task automatic model_edge();
        int unsigned q, h, v, xi, yi;
        edge_n++;
        if (edge_n % 2 == 1) begin
            q = (edge_n + 1) / 2 - 1;
            if (pos_vis(q)) begin
                m_rd       = m_mem[pos_addr(q)];
                m_rd_known = m_known[pos_addr(q)];
            end else begin
                m_rd       = '0;
                m_rd_known = 1'b1;
            end
            e_fs = 1'b0;
        end else begin
            q        = edge_n / 2 - 1;
            h        = q % HT;
            v        = (q / HT) % VT;
            e_blank  = (h < H_VIS) && (v < V_VIS);
            e_hs     = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
            e_vs     = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
            e_colour = e_blank ? m_rd : '0;
            e_ck     = e_blank ? m_rd_known : 1'b1;
            e_fs     = ((q + 1) % FRAME_Q) == 0;
        end
        xi = 32'(pix.x);
        yi = 32'(pix.y);
        if (m_busy) begin
            m_mem[m_addr]   = pix.bg_colour;
            m_known[m_addr] = 1'b1;
            if (pix.plot && m_drop < 255) m_drop++;
            if (m_addr == NPIX - 1) m_busy = 1'b0;
            else m_addr++;
        end else begin
            if (pix.plot) begin
                if (xi < H_RES && yi < V_RES) begin
                    m_mem[yi * H_RES + xi]   = pix.colour;
                    m_known[yi * H_RES + xi] = 1'b1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            if (pix.clear) begin
                m_busy = 1'b1;
                m_addr = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check("sync", 32'({vga_blank_n, vga_hs, vga_vs, frame_start, vga_pix_en, pix.busy}),
              32'({e_blank, e_hs, e_vs, e_fs, edge_n[0], m_busy}));
        check("drop", 32'(pix.drop_count), m_drop);
        if (e_ck) check("colour", 32'(vga_colour), 32'(e_colour));
        if (!vga_hs) hs_low++;
        if (!vga_vs) vs_low++;
        if (pix.busy) busy_cnt++;
        if (frame_start) begin
            if (fs_cnt == 0) fs_first = cyc;
            else fs_gap = cyc - fs_last;
            fs_last = cyc;
            fs_cnt++;
        end
        if (vga_blank_n) begin
            if (vga_colour == col_a) cnt_a++;
            if (vga_colour == col_b) cnt_b++;
        end else if (vga_colour != '0) begin
            bad_blank++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        check_outputs();
    endtask

    task automatic clear_stats();
        hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = 0; fs_last = 0; fs_gap = 0;
        busy_cnt = 0; cnt_a = 0; cnt_b = 0; bad_blank = 0;
    endtask

    task automatic idle_inputs();
        pix.plot = 1'b0; pix.clear = 1'b0; pix.x = '0; pix.y = '0;
        pix.colour = '0;
    endtask

    task automatic plot_one(input int unsigned xi, input int unsigned yi, input logic [COLOUR_W-1:0] c);
        pix.x = 9'(xi); pix.y = 8'(yi); pix.colour = c; pix.plot = 1'b1;
        tick();
        pix.plot = 1'b0;
    endtask

    // Asynchronous reset pulse starting between edges; outputs must fall to reset values at once.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 check("async_reset",
                 32'({pix.busy, pix.drop_count, vga_hs, vga_vs, vga_blank_n, vga_colour, frame_start, vga_pix_en}),
                 32'({1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}));
        idle_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; plots_in_clear = 0; found = 1'b0;
        col_a = '0; col_b = '0;
        for (int i = 0; i < NPIX; i++) begin
            m_mem[i] = '0; m_known[i] = 1'b0;
        end
        reset = 1'b1;
        idle_inputs();
        pix.bg_colour = '0;
        clear_stats();
        repeat (3) @(negedge clock);
        check("reset_state",
              32'({pix.busy, pix.drop_count, vga_hs, vga_vs, vga_blank_n, vga_colour, frame_start, vga_pix_en}),
              32'({1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}));
        reset = 1'b0;
        model_reset();

        // Two frames of raster timing.
        repeat (2 * FRAME_CLK) tick();
        check("hs_low_clocks", hs_low, 2 * VT * H_SYNC * 2);
        check("vs_low_clocks", vs_low, 2 * V_SYNC * HT * 2);
        check("frame_start_count", fs_cnt, 2);
        check("frame_start_first", fs_first, FRAME_CLK);
        check("frame_start_gap", fs_gap, FRAME_CLK);

        // Clear to black, with one in-range plot that must be dropped.
        clear_stats();
        pix.bg_colour = '0; pix.clear = 1'b1;
        tick();
        pix.clear = 1'b0;
        for (int i = 0; i < NPIX + 4; i++) begin
            pix.plot = (i == 10); pix.x = 9'd1; pix.y = 8'd1; pix.colour = 3'b111;
            tick();
        end
        pix.plot = 1'b0;
        check("clear_busy_clocks", busy_cnt, NPIX);
        check("drop_during_clear", 32'(pix.drop_count), 1);

        // Corner plots appear as 2x2 blocks.
        plot_one(0, 0, 3'b101);
        plot_one(H_RES - 1, V_RES - 1, 3'b011);
        repeat (4) tick();
        clear_stats(); col_a = 3'b101; col_b = 3'b011;
        repeat (FRAME_CLK) tick();
        check("colour_101_clocks", cnt_a, 8);
        check("colour_011_clocks", cnt_b, 8);
        check("blank_colour_zero", bad_blank, 0);

        // Out-of-range writes are counted and saturate.
        pulse_reset();
        plot_one(320, 0, 3'b111);
        plot_one(0, 240, 3'b111);
        plot_one(400, 250, 3'b111);
        check("drop_three", 32'(pix.drop_count), 3);
        for (int i = 0; i < 300; i++) plot_one($urandom_range(H_RES, 511), $urandom_range(0, 255), 3'($urandom));
        check("drop_saturate", 32'(pix.drop_count), 255);
        repeat (4) tick();
        clear_stats();
        repeat (FRAME_CLK) tick();
        check("ram_unchanged_101", cnt_a, 8);
        check("ram_unchanged_011", cnt_b, 8);

        // Clear to 010 with in-range plots rejected while busy.
        pulse_reset();
        clear_stats();
        pix.bg_colour = 3'b010; pix.clear = 1'b1;
        tick();
        pix.clear = 1'b0;
        for (int i = 0; i < NPIX + 4; i++) begin
            pix.plot = (i < NPIX) && (i % 16 == 3);
            if (pix.plot) plots_in_clear++;
            pix.x = 9'($urandom_range(0, H_RES - 1)); pix.y = 8'($urandom_range(0, V_RES - 1));
            pix.colour = 3'b110;
            tick();
        end
        pix.plot = 1'b0;
        check("clear2_busy_clocks", busy_cnt, NPIX);
        check("drop_plots_in_clear", 32'(pix.drop_count), plots_in_clear);
        repeat (4) tick();
        clear_stats(); col_a = 3'b010; col_b = 3'b000;
        repeat (FRAME_CLK) tick();
        check("all_visible_bg", cnt_a, 2 * H_VIS * V_VIS);
        check("blank_colour_zero2", bad_blank, 0);

        // Same-edge write to the pixel being scanned: old colour now, new colour next frame.
        for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
            if ((edge_n + 1) % 2 == 1 &&
                ((edge_n + 2) / 2 - 1) % HT == 10 && (((edge_n + 2) / 2 - 1) / HT) % VT == 6) found = 1'b1;
            else tick();
        end
        check("collision_found", 32'(found), 1);
        if (found) begin
            plot_one(5, 3, 3'b101);
            tick();
            check("collision_old", 32'(vga_colour), 32'(3'b010));
            repeat (FRAME_CLK) tick();
            check("collision_new", 32'(vga_colour), 32'(3'b101));
        end

        // Random traffic.
        for (int i = 0; i < 8000; i++) begin
            pix.plot      = ($urandom_range(0, 2) == 0);
            pix.x         = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, H_RES));
            pix.y         = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, V_RES));
            pix.colour    = 3'($urandom);
            pix.bg_colour = 3'($urandom);
            pix.clear     = ($urandom_range(0, 999) == 0);
            tick();
        end
        idle_inputs();
        repeat (NPIX + 4) tick();

        // Reset part-way through a clear leaves the buffer partially cleared.
        pix.bg_colour = 3'b111; pix.clear = 1'b1;
        tick();
        pix.clear = 1'b0;
        repeat (NPIX + 4) tick();
        pix.bg_colour = 3'b001; pix.clear = 1'b1;
        tick();
        pix.clear = 1'b0;
        repeat (PART_WR) tick();
        pulse_reset();
        repeat (4) tick();
        clear_stats(); col_a = 3'b001; col_b = 3'b111;
        repeat (FRAME_CLK) tick();
        check("partial_clear_new", cnt_a, PART_WR * 8);
        check("partial_clear_old", cnt_b, (NPIX - PART_WR) * 8);
        check("busy_after_reset", busy_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
